mpsoc_ahb3_master_port: RTL and testbench

MPSOC_AHB3_MASTER_PORT -- requirements
Module: mpsoc_ahb3_master_port

---
 rtl/mpsoc_ahb3_master_port.sv | 160 ++++++++++++++++
 tb/tb_mpsoc_ahb3_master_port.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_ahb3_master_port.sv
// AHB3-Lite single-transfer master port.
// Turns a valid/ready command stream into pipelined NONSEQ transfers and
// returns one response pulse per transfer, in command order. A two-cycle
// ERROR response cancels the transfer waiting in its address phase; that
// transfer is re-issued once the error has been reported.
//
// state | meaning
// RUN   | normal pipelined operation, commands accepted while HREADY=1
// ERR1  | first ERROR cycle seen, bus idled, waiting for the second cycle
// RETRY | re-drive the cancelled address phase, then return to RUN
module mpsoc_ahb3_master_port #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [PLEN-1:0] cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [XLEN-1:0] cmd_wdata,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ERR1  = 2'd1,
        RETRY = 2'd2
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t          state_q;
    logic            hsel_q;
    logic [PLEN-1:0] haddr_q;
    logic            hwrite_q;
    logic [2:0]      hsize_q;
    logic [1:0]      htrans_q;
    logic [XLEN-1:0] pend_wdata_q;   // write data of the command in address phase
    logic [XLEN-1:0] hwdata_q;
    logic            dp_active_q;
    logic            dp_write_q;
    logic            cancel_q;       // an address phase was cancelled by ERROR
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;
    logic            accept;

    // HRESETn gates cmd_ready so nothing is offered while the port is held in reset.
    assign cmd_ready = HREADY & (state_q == RUN) & HRESETn;
    assign accept    = cmd_valid & cmd_ready;

    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Address/data phase pipeline, error recovery FSM and response register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= RUN;
            hsel_q       <= 1'b0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'b000;
            htrans_q     <= TRANS_IDLE;
            pend_wdata_q <= '0;
            hwdata_q     <= '0;
            dp_active_q  <= 1'b0;
            dp_write_q   <= 1'b0;
            cancel_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (dp_active_q && !HREADY && HRESP) begin
                        // First ERROR cycle: idle the bus, keep the address phase for retry.
                        cancel_q <= (htrans_q == TRANS_NONSEQ);
                        htrans_q <= TRANS_IDLE;
                        hsel_q   <= 1'b0;
                        state_q  <= ERR1;
                    end else if (HREADY) begin
                        if (dp_active_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
                            rsp_err_q   <= HRESP;
                        end
                        dp_active_q <= (htrans_q == TRANS_NONSEQ);
                        if (htrans_q == TRANS_NONSEQ) begin
                            dp_write_q <= hwrite_q;
                            if (hwrite_q) begin
                                hwdata_q <= pend_wdata_q;
                            end
                        end
                        if (accept) begin
                            hsel_q       <= 1'b1;
                            htrans_q     <= TRANS_NONSEQ;
                            haddr_q      <= cmd_addr;
                            hwrite_q     <= cmd_write;
                            hsize_q      <= cmd_size;
                            pend_wdata_q <= cmd_wdata;
                        end else begin
                            hsel_q   <= 1'b0;
                            htrans_q <= TRANS_IDLE;
                        end
                    end
                end
                ERR1: begin
                    if (HREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
                        rsp_err_q   <= 1'b1;
                        dp_active_q <= 1'b0;
                        state_q     <= cancel_q ? RETRY : RUN;
                    end
                end
                RETRY: begin
                    if (HREADY) begin
                        hsel_q   <= 1'b1;
                        htrans_q <= TRANS_NONSEQ;
                        cancel_q <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_master_port.sv
// Bench for mpsoc_ahb3_master_port: a small AHB slave memory, a response
// scoreboard filled at command acceptance and drained on rsp_valid, and
// one task per scenario.
module tb_mpsoc_ahb3_master_port;
    localparam int XLEN = 64;
    localparam int PLEN = 64;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [PLEN-1:0] cmd_addr;
    logic [2:0]      cmd_size;
    logic [XLEN-1:0] cmd_wdata;
    logic            rsp_valid, rsp_err;
    logic [XLEN-1:0] rsp_rdata;
    logic            HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA, HRDATA;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              checks = 0;
    int              errors = 0;
    int              rsp_cnt = 0;
    logic [XLEN-1:0] exp_mem[32];
    logic [XLEN-1:0] slv_mem[32];
    logic            slv_inited = 1'b0;
    logic            slv_dp_valid, slv_dp_write;
    logic [4:0]      slv_dp_idx;

    always #5 HCLK = ~HCLK;

    mpsoc_ahb3_master_port #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Slave memory: tracks the data phase and commits writes that finish OKAY.
    assign HRDATA = slv_dp_valid ? slv_mem[slv_dp_idx] : '0;

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            slv_dp_valid <= 1'b0;
            slv_dp_write <= 1'b0;
            slv_dp_idx   <= 5'd0;
            if (!slv_inited) begin
                for (int i = 0; i < 32; i++) slv_mem[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
                slv_inited <= 1'b1;
            end
        end else if (HREADY) begin
            if (slv_dp_valid && slv_dp_write && !HRESP) slv_mem[slv_dp_idx] <= HWDATA;
            slv_dp_valid <= HSEL && (HTRANS == 2'b10);
            slv_dp_write <= HWRITE;
            slv_dp_idx   <= HADDR[7:3];
        end
    end

    // Scoreboard drain on every response pulse.
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            rsp_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b want no response", rsp_rdata, rsp_err);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_data got rdata=%h err=%b want rdata=%h err=%b",
                             rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [XLEN-1:0] d, input logic e);
        exp_t r;
        r.rdata = d;
        r.err   = e;
        return r;
    endfunction

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h40;
        cmd_size = 3'd3; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (HTRANS !== 2'b00 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got htrans=%b cmd_ready=%b rsp_valid=%b want 00 0 0",
                         i, HTRANS, cmd_ready, rsp_valid);
            end
        end
        checks++;
        if (HSEL !== 1'b0 || HADDR !== 64'h0 || HWDATA !== 64'h0 || HWRITE !== 1'b0 ||
            HSIZE !== 3'd0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got hsel=%b haddr=%h hwdata=%h hwrite=%b hsize=%0d rdata=%h err=%b want all zero",
                     HSEL, HADDR, HWDATA, HWRITE, HSIZE, rsp_rdata, rsp_err);
        end
        checks++;
        if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            errors++;
            $display("FAIL fixed_attrs got hburst=%b hprot=%b hmastlock=%b want 000 0011 0",
                     HBURST, HPROT, HMASTLOCK);
        end
        cmd_valid = 1'b0;
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int n0;
        n0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h10; cmd_size = 3'd3; cmd_wdata = 64'hA5A5;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready);
        end
        exp_mem[2] = 64'hA5A5;
        sb.push_back(mk(64'h0, 1'b0));
        tick();
        checks++;
        if (HTRANS !== 2'b10 || HSEL !== 1'b1 || HADDR !== 64'h10 || HWRITE !== 1'b1 || HSIZE !== 3'd3) begin
            errors++;
            $display("FAIL wr_addr_phase got htrans=%b hsel=%b haddr=%h hwrite=%b hsize=%0d want 10 1 10 1 3",
                     HTRANS, HSEL, HADDR, HWRITE, HSIZE);
        end
        cmd_write = 1'b0;
        sb.push_back(mk(exp_mem[2], 1'b0));
        tick();
        checks++;
        if (HWDATA !== 64'hA5A5 || HWRITE !== 1'b0 || HTRANS !== 2'b10 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_data_phase got hwdata=%h hwrite=%b htrans=%b rsp_valid=%b want a5a5 0 10 0",
                     HWDATA, HWRITE, HTRANS, rsp_valid);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== (i < 2)) begin
                errors++;
                $display("FAIL wr_rd_rsp_timing cyc=%0d got rsp_valid=%b want %b", i, rsp_valid, (i < 2));
            end
        end
        checks++;
        if (rsp_cnt - n0 !== 2) begin
            errors++; $display("FAIL wr_rd_rsp_count got %0d want 2", rsp_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [PLEN-1:0] a[4];
        int n0;
        a[0] = 64'h00; a[1] = 64'h08; a[2] = 64'h18; a[3] = 64'h30;
        n0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd3;
        for (int i = 0; i < 4; i++) begin
            cmd_addr = a[i];
            sb.push_back(mk(exp_mem[a[i][7:3]], 1'b0));
            tick();
            checks++;
            if (HTRANS !== 2'b10 || HADDR !== a[i] || rsp_valid !== (i >= 2)) begin
                errors++;
                $display("FAIL b2b_issue cyc=%0d got htrans=%b haddr=%h rsp_valid=%b want 10 %h %b",
                         i, HTRANS, HADDR, rsp_valid, a[i], (i >= 2));
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== (i < 2)) begin
                errors++;
                $display("FAIL b2b_rsp_tail cyc=%0d got rsp_valid=%b want %b", i, rsp_valid, (i < 2));
            end
        end
        checks++;
        if (rsp_cnt - n0 !== 4) begin
            errors++; $display("FAIL b2b_rsp_count got %0d want 4", rsp_cnt - n0);
        end
    endtask

    task automatic test_wait_states();
        int n0;
        logic [XLEN-1:0] d;
        d = 64'h1234_5678_9ABC_DEF0;
        n0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h48; cmd_size = 3'd3; cmd_wdata = d;
        exp_mem[9] = d;
        sb.push_back(mk(64'h0, 1'b0));
        tick();
        cmd_write = 1'b0;
        sb.push_back(mk(exp_mem[9], 1'b0));
        tick();
        HREADY = 1'b0; cmd_addr = 64'h50;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            checks++;
            if (HADDR !== 64'h48 || HWDATA !== d || HTRANS !== 2'b10 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold cyc=%0d got haddr=%h hwdata=%h htrans=%b rsp_valid=%b cmd_ready=%b want 48 %h 10 0 0",
                         i, HADDR, HWDATA, HTRANS, rsp_valid, cmd_ready, d);
            end
        end
        HREADY = 1'b1;
        sb.push_back(mk(exp_mem[10], 1'b0));
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wait_release_ready got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL wait_wr_rsp got rsp_valid=%b want 1", rsp_valid);
        end
        tick(); tick(); tick();
        checks++;
        if (rsp_cnt - n0 !== 3 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_rsp_count got %0d rsp_valid=%b want 3 0", rsp_cnt - n0, rsp_valid);
        end
    endtask

    task automatic test_error_retry();
        int n0;
        logic [XLEN-1:0] d;
        d = 64'hDEAD_BEEF_0000_0028;
        n0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h20; cmd_size = 3'd3;
        sb.push_back(mk(exp_mem[4], 1'b1));
        tick();
        cmd_write = 1'b1; cmd_addr = 64'h28; cmd_wdata = d;
        exp_mem[5] = d;
        sb.push_back(mk(64'h0, 1'b0));
        tick();
        cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
        tick();
        checks++;
        if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_cancel got htrans=%b rsp_valid=%b want 00 0", HTRANS, rsp_valid);
        end
        HREADY = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL err_no_accept got cmd_ready=%b want 0", cmd_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL err_report got rsp_valid=%b htrans=%b want 1 00", rsp_valid, HTRANS);
        end
        HRESP = 1'b0;
        tick();
        checks++;
        if (HTRANS !== 2'b10 || HSEL !== 1'b1 || HADDR !== 64'h28 || HWRITE !== 1'b1 || HSIZE !== 3'd3) begin
            errors++;
            $display("FAIL err_retry got htrans=%b hsel=%b haddr=%h hwrite=%b hsize=%0d want 10 1 28 1 3",
                     HTRANS, HSEL, HADDR, HWRITE, HSIZE);
        end
        tick();
        checks++;
        if (HWDATA !== d || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_retry_data got hwdata=%h rsp_valid=%b want %h 0", HWDATA, rsp_valid, d);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_cnt - n0 !== 2) begin
            errors++;
            $display("FAIL err_retry_rsp got rsp_valid=%b count=%0d want 1 2", rsp_valid, rsp_cnt - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [XLEN-1:0] old;
        old = exp_mem[14];
        n0 = rsp_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h70; cmd_size = 3'd3; cmd_wdata = 64'h7777_0000_7777_0000;
        sb.push_back(mk(64'h0, 1'b0));
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (HWDATA !== 64'h7777_0000_7777_0000) begin
            errors++; $display("FAIL rstmid_data_phase got hwdata=%h want 7777000077770000", HWDATA);
        end
        HRESETn = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 64'h0 || HWDATA !== 64'h0 ||
            rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_values got htrans=%b hsel=%b haddr=%h hwdata=%h rsp_valid=%b cmd_ready=%b want reset values",
                     HTRANS, HSEL, HADDR, HWDATA, rsp_valid, cmd_ready);
        end
        tick(); tick();
        HRESETn = 1'b1;
        tick();
        checks++;
        if (rsp_cnt !== n0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_rsp got count=%0d rsp_valid=%b want %0d 0", rsp_cnt, rsp_valid, n0);
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h70;
        sb.push_back(mk(old, 1'b0));
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 64'h70 || HWRITE !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_fresh got htrans=%b haddr=%h hwrite=%b want 10 70 0", HTRANS, HADDR, HWRITE);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL rstmid_rsp got rsp_valid=%b count=%0d want 1 1", rsp_valid, rsp_cnt - n0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = 3'd0; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_error_retry();
        test_reset_mid();
        tick(); tick(); tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_drained got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
